// File: rtl/timer_pkg.sv
// Shared constants and types for the time display path: field layout of the
// packed time bus, seven-segment patterns, view codes and controller states.
package timer_pkg;

   localparam int TIME_W  = 27;
   localparam int MS_LSB  = 0;
   localparam int MS_W    = 10;
   localparam int SEC_LSB = 10;
   localparam int SEC_W   = 6;
   localparam int MIN_LSB = 16;
   localparam int MIN_W   = 6;
   localparam int HR_LSB  = 22;
   localparam int HR_W    = 5;

   // {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_LUT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      VIEW_MMSS = 2'd0,
      VIEW_HHMM = 2'd1,
      VIEW_SSCC = 2'd2,
      VIEW_ALT  = 2'd3
   } view_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      if (d > 4'd9) return SEG_BLANK;
      return SEG_LUT[d];
   endfunction

endpackage

// File: rtl/timer_display_if.sv
// Bundle between the timer's packed time bus and the display pins.
interface timer_display_if;
   logic [26:0] out_time;
   logic [1:0]  view_sel;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        busy;

   modport master (output out_time, view_sel, input seg, dp, an, busy);
   modport slave  (input out_time, view_sel, output seg, dp, an, busy);
endinterface

// File: rtl/bin2bcd10.sv
// Iterative double-dabble: 10-bit binary to 3 BCD digits in 1 load + 10 shifts.
// done pulses with the final shift; bcd holds the result from the next cycle until the next start.
module bin2bcd10 (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [9:0]  bin,
   output logic        done,
   output logic [11:0] bcd
);

   logic [21:0] sh_q;
   logic [3:0]  cnt_q;
   logic        busy_q;

   function automatic logic [21:0] dd_step(input logic [21:0] s);
      logic [21:0] t;
      t = s;
      for (int i = 0; i < 3; i++) begin
         if (t[10+4*i +: 4] > 4'd4) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
      end
      return t << 1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (busy_q) begin
         sh_q  <= dd_step(sh_q);
         cnt_q <= cnt_q - 4'd1;
         if (cnt_q == 4'd1) busy_q <= 1'b0;
      end else if (start) begin
         sh_q   <= {12'd0, bin};
         cnt_q  <= 4'd10;
         busy_q <= 1'b1;
      end
   end

   assign done = busy_q && (cnt_q == 4'd1);
   assign bcd  = sh_q[21:10];

endmodule

// File: rtl/timer_display.sv
// Snapshots the packed time, converts each field to BCD and scans a 4-digit
// active-low seven-segment display.
//   state     | meaning
//   ST_IDLE   | waiting for a snapshot tick
//   ST_CONV   | converting hr, min, sec, ms in turn
//   ST_COMMIT | copying all 12 digits to the display buffer
module timer_display
   import timer_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int SNAP_DIV = 1000000
) (
   input logic            clk,
   input logic            reset,
   timer_display_if.slave bus
);

   localparam int SNAP_W = (SNAP_DIV > 1) ? $clog2(SNAP_DIV) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SNAP_W-1:0] SNAP_TC = SNAP_W'(SNAP_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_TC = SCAN_W'(SCAN_DIV - 1);

   logic [SNAP_W-1:0] snap_cnt;
   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        slot_q;
   logic              snap_tick, scan_tick;

   logic [TIME_W-1:0] snap_q;
   state_e            state_q, state_d;
   logic [1:0]        field_q, field_d;
   logic              launch_q, launch_d;
   logic              start, done, commit;
   logic [9:0]        conv_bin;
   logic [11:0]       conv_bcd;
   logic [35:0]       stage_q;
   logic [47:0]       disp_q;
   logic [3:0]        digit_idx;
   logic [3:0]        digit;

   logic [6:0] seg_q;
   logic [3:0] an_q;
   logic       dp_q;

   assign snap_tick = (snap_cnt == SNAP_TC);
   assign scan_tick = (scan_cnt == SCAN_TC);

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_cnt <= '0;
         scan_cnt <= '0;
         slot_q   <= '0;
      end else begin
         snap_cnt <= snap_tick ? '0 : snap_cnt + 1'b1;
         scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
         if (scan_tick) slot_q <= slot_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         field_q  <= '0;
         launch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         field_q  <= field_d;
         launch_q <= launch_d;
      end
   end

   // Ticks arriving outside IDLE are dropped rather than queued.
   always_comb begin
      state_d  = state_q;
      field_d  = field_q;
      launch_d = 1'b0;
      start    = 1'b0;
      commit   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (snap_tick) begin
               state_d  = ST_CONV;
               field_d  = 2'd0;
               launch_d = 1'b1;
            end
         end
         ST_CONV: begin
            start = launch_q;
            if (done) begin
               if (field_q == 2'd3) begin
                  state_d = ST_COMMIT;
               end else begin
                  field_d  = field_q + 2'd1;
                  launch_d = 1'b1;
               end
            end
         end
         ST_COMMIT: begin
            commit  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)                              snap_q <= '0;
      else if (state_q == ST_IDLE && snap_tick) snap_q <= bus.out_time;
   end

   always_comb begin
      case (field_q)
         2'd0:    conv_bin = 10'(snap_q[HR_LSB +: HR_W]);
         2'd1:    conv_bin = 10'(snap_q[MIN_LSB +: MIN_W]);
         2'd2:    conv_bin = 10'(snap_q[SEC_LSB +: SEC_W]);
         default: conv_bin = snap_q[MS_LSB +: MS_W];
      endcase
   end

   bin2bcd10 u_bcd (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (conv_bin),
      .done  (done),
      .bcd   (conv_bcd)
   );

   // A field's result is still held by the engine while the next field loads.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
      end else if (start) begin
         case (field_q)
            2'd1:    stage_q[35:24] <= conv_bcd;
            2'd2:    stage_q[23:12] <= conv_bcd;
            2'd3:    stage_q[11:0]  <= conv_bcd;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)       disp_q <= '0;
      else if (commit) disp_q <= {stage_q, conv_bcd};
   end

   // disp_q digit index: ms 0..2, sec 3..5, min 6..8, hr 9..11 (ones first)
   always_comb begin
      digit_idx = 4'd0;
      case (bus.view_sel)
         VIEW_HHMM: begin
            case (slot_q)
               2'd3:    digit_idx = 4'd10;
               2'd2:    digit_idx = 4'd9;
               2'd1:    digit_idx = 4'd7;
               default: digit_idx = 4'd6;
            endcase
         end
         VIEW_SSCC: begin
            case (slot_q)
               2'd3:    digit_idx = 4'd4;
               2'd2:    digit_idx = 4'd3;
               2'd1:    digit_idx = 4'd2;
               default: digit_idx = 4'd1;
            endcase
         end
         VIEW_MMSS, VIEW_ALT: begin
            case (slot_q)
               2'd3:    digit_idx = 4'd7;
               2'd2:    digit_idx = 4'd6;
               2'd1:    digit_idx = 4'd4;
               default: digit_idx = 4'd3;
            endcase
         end
         default: digit_idx = 4'd3;
      endcase
   end

   assign digit = disp_q[{digit_idx, 2'b00} +: 4];

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q <= SEG_BLANK;
         an_q  <= 4'b1111;
         dp_q  <= 1'b1;
      end else begin
         seg_q <= seg_decode(digit);
         an_q  <= ~(4'b0001 << slot_q);
         dp_q  <= (slot_q != 2'd2);
      end
   end

   assign bus.seg  = seg_q;
   assign bus.an   = an_q;
   assign bus.dp   = dp_q;
   assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: doc/timer_display.md
# timer_display

Downstream consumer of the timer's packed `out_time` bus. It periodically snapshots the running time and converts the selected fields to BCD with an iterative double-dabble engine. It drives a 4-digit, active-low, multiplexed seven-segment display on the board. It is the last stage before the FPGA pins, and it holds no timing state of its own beyond the display refresh.

## Interface
- `SCAN_DIV`, default 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz).
- `SNAP_DIV`, default 1000000: clk cycles between snapshots (100 Hz).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `out_time`  in  27  packed time, `{hr[4:0], min[5:0], sec[5:0], ms[9:0]}`.
- `view_sel`  in  2  0 = MM.SS, 1 = HH.MM, 2 = SS.cc (ms hundreds and tens), 3 = treated as 0.
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  4  digit enables, active-low; `an[0]` is the rightmost digit.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Snapshot counter counts 0..SNAP_DIV-1. At terminal count it issues `snap_tick`.
  - If the FSM is IDLE, `out_time` is latched into the snapshot register.
  - If the FSM is not IDLE, the tick is dropped, not queued.
- FSM states:
  - IDLE → CONV on `snap_tick`.
  - CONV runs four fields in order hr, min, sec, ms.
  - CONV → COMMIT after the ms field completes.
  - COMMIT → IDLE.
- Each field is zero-extended to 10 bits and converted to 3 BCD digits. Maximum values are hr 31, min/sec 63, ms 999.
  - Out-of-range values such as sec = 61 are displayed literally; no clamping.
- COMMIT writes all 12 BCD digits into the display buffer in one cycle. The display never shows a mix of two snapshots.
- Scan counter: the slot index increments 0→1→2→3→0 every SCAN_DIV cycles. Slot n drives `an[n]` low and the other three `an` bits high.
- Digit mapping, slot 3..0:
  - view 0: min tens, min ones, sec tens, sec ones.
  - view 1: hr tens, hr ones, min tens, min ones.
  - view 2: sec tens, sec ones, ms hundreds, ms tens.
- `dp` is low only in slot 2, for all views.
- Seven-segment patterns for digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- BCD values 10–15 cannot occur. If one reaches the decoder it is blanked (1111111).
- `view_sel` is sampled combinationally per slot. A change takes effect in the current slot.

## Timing
- Reset values:
  - `an` = 4'b1111, `seg` = 7'b1111111, `dp` = 1, `busy` = 0.
  - Display buffer, snapshot register, both counters and slot index = 0. FSM = IDLE.
- The first slot is driven on the cycle after reset deasserts: `an` = 4'b1110, and the buffer displays zeros.
- Latency, counting the `snap_tick` cycle as cycle 0:
  - Snapshot is latched at the end of cycle 0.
  - Each field takes 11 cycles: 1 load plus 10 shift/add-3 cycles.
  - Fields occupy cycles 1–44. COMMIT is cycle 45, and the new buffer is visible from cycle 46.
- `busy` is high in cycles 1–45 inclusive.
- With SNAP_DIV ≥ 46, no tick is ever dropped.
- Outputs `seg`, `an`, `dp` are registered: one cycle behind the slot index and buffer.
- Reset asserted mid-conversion aborts it. The buffer keeps no partial result; every register returns to its reset value.
- Counters wrap at terminal count with no idle cycle.

## Structure
- Package `timer_pkg` holds:
  - Field offsets and widths of `out_time`: MS_LSB 0, SEC_LSB 10, MIN_LSB 16, HR_LSB 22.
  - The 10-entry seven-segment pattern constant.
  - The view_sel encodings and the FSM state enum.
- Sub-module `bin2bcd10`: sequential 10-bit to 3-digit double-dabble.
  - Interface: `start`/`done` handshake, `done` a 1-cycle pulse.
  - `start` while busy is ignored.
- All remaining logic is instantiated directly in the top: counters, FSM, buffer and decoder.

## Test plan
- Run all scenarios with SCAN_DIV = 4 and SNAP_DIV = 64.
- Reset, then hold `out_time` = 0 → `an` scans 1110, 1101, 1011, 0111, with 4 cycles per slot; `seg` = 1000000 in every slot; `dp` low only when `an` = 1011.
- `out_time` = {5'd13, 6'd7, 6'd42, 10'd986}, view 0 → buffer updates on cycle 46 after the tick; slots 3..0 show 0, 7, 4, 2. View 1 → 1, 3, 0, 7. View 2 → 4, 2, 9, 8.
- Change `out_time` during cycles 1–45 of a conversion → the displayed digits reflect the value latched at cycle 0; the new value appears after the next snapshot.
- Field maxima hr 31, min 63, sec 63, ms 999, view 0 → 6, 3, 6, 3. View 2 → 6, 3, 9, 9.
- Assert reset at cycle 20 of a conversion → all outputs return to reset values the next cycle; `busy` = 0; display shows zeros until the next full commit.
- view_sel = 3 → output identical to view 0, checked cycle by cycle.
